// File: rtl/sum_stream_pkg.sv
// Shared types and arithmetic for the running-sum delta decoder.
// Holds the FSM state enum, a default-width FIFO entry and the modular subtract helper.
package sum_stream_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 64;

  typedef enum logic {
    SYNC,
    RUN
  } state_t;

  typedef struct packed {
    logic                     first;
    logic [DEFAULT_WIDTH-1:0] delta;
  } sum_entry_t;

  // Callers truncate the result to their own width; the low bits are the modular difference.
  function automatic logic [MAX_WIDTH-1:0] sum_delta(input logic [MAX_WIDTH-1:0] a,
                                                     input logic [MAX_WIDTH-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/sum_delta_decoder_if.sv
// Producer/consumer bundle of the delta decoder: sum input handshake and delta output handshake.
// The decoder uses the slave view; the driving environment uses the master view.
interface sum_delta_decoder_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic             IN_valid;
  logic             OUT_ready;
  logic [WIDTH-1:0] IN_sum;
  logic             IN_restart;
  logic             OUT_valid;
  logic             IN_ready;
  logic [WIDTH-1:0] OUT_delta;
  logic             OUT_first;
  logic [CNT_W-1:0] OUT_count;

  modport slave (
    input  IN_valid, IN_sum, IN_restart, IN_ready,
    output OUT_ready, OUT_valid, OUT_delta, OUT_first, OUT_count
  );

  modport master (
    output IN_valid, IN_sum, IN_restart, IN_ready,
    input  OUT_ready, OUT_valid, OUT_delta, OUT_first, OUT_count
  );

endinterface

// File: rtl/sum_entry_fifo.sv
// Circular-buffer FIFO of decoded entries; extra pointer MSB separates full from empty.
// The head reads zero while empty so downstream never sees stale storage.
module sum_entry_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = sum_stream_pkg::sum_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  entry_t entry_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  entry_t      mem_q [DEPTH];

  // NOTE: storage has no reset; pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sum_delta_decoder.sv
// Turns a stream of running sums back into per-sample increments, queued in a small output FIFO.
// The first sample after reset or restart has no predecessor and is passed through flagged first.
module sum_delta_decoder
  import sum_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                IN_clk,
  input  logic                IN_rst_n,
  sum_delta_decoder_if.slave  bus
);

  typedef struct packed {
    logic             first;
    logic [WIDTH-1:0] delta;
  } entry_t;

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] count_q;
  entry_t           entry_d;
  entry_t           head;
  logic             first_d;
  logic             accept;
  logic             pop;
  logic             full;
  logic             empty;

  assign pop           = !empty && bus.IN_ready;
  // Pass-through at full: a pop in the same cycle frees the slot being written.
  assign bus.OUT_ready = IN_rst_n && (!full || pop);
  assign accept        = bus.IN_valid && bus.OUT_ready;

  // NOTE: every field gets a value on every path so no latch is inferred.
  always_comb begin
    first_d       = (state_q == SYNC) || bus.IN_restart;
    entry_d.first = first_d;
    entry_d.delta = first_d ? bus.IN_sum
                            : WIDTH'(sum_delta(MAX_WIDTH'(bus.IN_sum), MAX_WIDTH'(prev_q)));
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state_q <= SYNC;
      prev_q  <= '0;
    end else if (accept) begin
      prev_q  <= bus.IN_sum;
      state_q <= RUN;
    end else if (bus.IN_restart) begin
      state_q <= SYNC;
    end
  end

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n)                count_q <= '0;
    else if (pop && count_q != '1) count_q <= count_q + CNT_W'(1);
  end

  sum_entry_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (IN_clk),
    .rst_n   (IN_rst_n),
    .push_i  (accept),
    .entry_i (entry_d),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.OUT_valid = !empty;
  assign bus.OUT_delta = head.delta;
  assign bus.OUT_first = head.first;
  assign bus.OUT_count = count_q;

endmodule
